// File: rtl/xint_pkg.sv
// External interrupt conditioner shared definitions: register addresses, mode encodings, defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   SYNC_STAGES_DEF  default depth of the per-pin synchronizer
//   NUM_CH           number of interrupt channels
//   cr_adr_e         control-register address map
//   mode_e           per-channel trigger mode
//   is_cfg_adr()     true for registers whose write restarts debounce timing
package xint_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int NUM_CH          = 8;

  typedef enum logic [2:0] {
    ADR_MODE0 = 3'h0,  // modes ch3..0, two bits each, ch0 in [1:0]
    ADR_MODE1 = 3'h1,  // modes ch7..4
    ADR_DBEN  = 3'h2,  // per-channel debounce enable
    ADR_DBPRE = 3'h3,  // prescaler reload value
    ADR_DBTH  = 3'h4,  // debounce threshold in [3:0]
    ADR_RAW   = 3'h5,  // synchronized pin state, read-only
    ADR_FILT  = 3'h6,  // filtered pin state, read-only
    ADR_RSVD  = 3'h7   // reads zero
  } cr_adr_e;

  typedef enum logic [1:0] {
    MODE_DIS   = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_LEVEL = 2'b11
  } mode_e;

  // Writes to any debounce timing register restart every counter and the
  // prescaler so a half-finished count never mixes old and new settings.
  function automatic logic is_cfg_adr(input logic [2:0] adr);
    return (adr == ADR_DBEN) || (adr == ADR_DBPRE) || (adr == ADR_DBTH);
  endfunction

endpackage

// File: rtl/xint_cond_ch.sv
// One interrupt channel: pin synchronizer, tick-based debounce filter, edge/level detect.
// Latency: pin to int_out is SYNC_STAGES+2 clocks with debounce off; debounce adds (th+1) ticks.
// Backpressure: none; int_out is a registered request level/pulse, never stalled.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   pin        raw asynchronous external pin
//   mode       trigger mode (disabled / rising / falling / level-high)
//   dben       debounce enable for this channel
//   tick       one-cycle prescaler strobe that paces the debounce counter
//   clr        restart the debounce counter (timing register written)
//   th         debounce threshold; filt follows raw after th+1 disagreeing ticks
//   raw        last synchronizer stage
//   filt       filtered pin state
//   int_out    conditioned interrupt request
module xint_cond_ch
  import xint_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin,
  input  mode_e      mode,
  input  logic       dben,
  input  logic       tick,
  input  logic       clr,
  input  logic [3:0] th,
  output logic       raw,
  output logic       filt,
  output logic       int_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             cnt_q;
  logic [3:0]             cnt_nxt;
  logic                   filt_q;
  logic                   filt_nxt;
  logic                   filt_d_q;
  logic                   int_q;
  logic                   int_nxt;

  // Synchronizer: bit 0 takes the pin, the top bit is the metastability-safe copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign raw = sync_q[SYNC_STAGES-1];

  // Debounce: the counter holds the number of consecutive ticks on which raw
  // has disagreed with filt. Any agreement (or a timing-register write) drops
  // the count, so a glitch shorter than th+1 ticks never reaches filt.
  always_comb begin
    filt_nxt = filt_q;
    cnt_nxt  = cnt_q;
    if (!dben) begin
      filt_nxt = raw;
      cnt_nxt  = 4'd0;
    end else if (clr || (raw == filt_q)) begin
      cnt_nxt  = 4'd0;
    end else if (tick) begin
      // cnt_q ticks already seen; this tick makes cnt_q+1, which exceeds th
      // exactly when cnt_q >= th.
      if (cnt_q >= th) begin
        filt_nxt = raw;
        cnt_nxt  = 4'd0;
      end else begin
        cnt_nxt  = cnt_q + 4'd1;
      end
    end
  end

  // Edge detection looks only at filt vs its delayed copy, so a mode change
  // on its own can never manufacture a pulse.
  always_comb begin
    int_nxt = 1'b0;
    unique case (mode)
      MODE_RISE:  int_nxt = filt_q & ~filt_d_q;
      MODE_FALL:  int_nxt = ~filt_q & filt_d_q;
      MODE_LEVEL: int_nxt = filt_q;
      default:    int_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 4'd0;
      filt_q   <= 1'b0;
      filt_d_q <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_nxt;
      filt_q   <= filt_nxt;
      filt_d_q <= filt_q;
      int_q    <= int_nxt;
    end
  end

  assign filt    = filt_q;
  assign int_out = int_q;

endmodule

// File: rtl/xint_cond.sv
// Eight-channel external interrupt conditioner with a small control-register block.
// Latency: pin to INT_OUT is SYNC_STAGES+2 clocks with debounce off; register reads are combinational.
// Backpressure: none; register writes always complete in one clock, INT_OUT is never stalled.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   XINT_PIN   asynchronous external interrupt pins, one per channel
//   INT_OUT    registered conditioned requests to the interrupt controller
//   cr_din     control-register write data
//   cr_dout    control-register read data, combinational from cr_adr
//   cr_adr     control-register address
//   cr_we      write strobe, qualified by cr_cs
//   cr_cs      block select
module xint_cond
  import xint_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] XINT_PIN,
  output logic [7:0] INT_OUT,
  input  logic [7:0] cr_din,
  output logic [7:0] cr_dout,
  input  logic [2:0] cr_adr,
  input  logic       cr_we,
  input  logic       cr_cs
);

  // A single flop cannot synchronize; shallower settings are raised to two.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [15:0]       mode_q;
  logic [7:0]        dben_q;
  logic [7:0]        dbpre_q;
  logic [3:0]        dbth_q;
  logic [7:0]        pre_cnt_q;
  logic              tick;
  logic              wr;
  logic              cfg_wr;
  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] filt_vec;
  logic [NUM_CH-1:0] int_vec;

  assign wr     = cr_cs & cr_we;
  assign cfg_wr = wr & is_cfg_adr(cr_adr);

  // ---------------------------------------------------------------------
  // Control registers. RAW, FILT and the reserved slot have no storage, so
  // writes there simply fall through the default arm.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 16'h0000;
      dben_q  <= 8'h00;
      dbpre_q <= 8'h00;
      dbth_q  <= 4'h0;
    end else if (wr) begin
      case (cr_adr_e'(cr_adr))
        ADR_MODE0: mode_q[7:0]  <= cr_din;
        ADR_MODE1: mode_q[15:8] <= cr_din;
        ADR_DBEN:  dben_q       <= cr_din;
        ADR_DBPRE: dbpre_q      <= cr_din;
        ADR_DBTH:  dbth_q       <= cr_din[3:0];
        default:   ;
      endcase
    end
  end

  always_comb begin
    cr_dout = 8'h00;
    case (cr_adr_e'(cr_adr))
      ADR_MODE0: cr_dout = mode_q[7:0];
      ADR_MODE1: cr_dout = mode_q[15:8];
      ADR_DBEN:  cr_dout = dben_q;
      ADR_DBPRE: cr_dout = dbpre_q;
      ADR_DBTH:  cr_dout = {4'h0, dbth_q};
      ADR_RAW:   cr_dout = raw_vec;
      ADR_FILT:  cr_dout = filt_vec;
      default:   cr_dout = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------
  // Debounce prescaler: strobes when the count reaches the reload value and
  // restarts from zero, giving one tick every dbpre_q+1 clocks. If the reload
  // is lowered below the running count, the count wraps through 255 first;
  // that cannot happen in practice because such a write also clears it.
  // ---------------------------------------------------------------------
  assign tick = (pre_cnt_q == dbpre_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= 8'h00;
    end else if (cfg_wr || tick) begin
      pre_cnt_q <= 8'h00;
    end else begin
      pre_cnt_q <= pre_cnt_q + 8'h01;
    end
  end

  // ---------------------------------------------------------------------
  // Channels: fully independent, so simultaneous events on several pins
  // assert their own request bits in the same cycle.
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    xint_cond_ch #(
      .SYNC_STAGES (SYNC_N)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .pin     (XINT_PIN[i]),
      .mode    (mode_e'(mode_q[2*i +: 2])),
      .dben    (dben_q[i]),
      .tick    (tick),
      .clr     (cfg_wr),
      .th      (dbth_q),
      .raw     (raw_vec[i]),
      .filt    (filt_vec[i]),
      .int_out (int_vec[i])
    );
  end

  assign INT_OUT = int_vec;

endmodule

// File: tb/tb_xint_cond.sv
// Self-checking bench for xint_cond: directed scenarios plus randomized pins and register traffic.
// Expected INT_OUT per clock comes from a behavioural model and is queued; a negedge monitor pops and compares.
// Register reads are compared against the model's architectural view of the register map.
module tb_xint_cond;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] XINT_PIN;
  logic [7:0] INT_OUT;
  logic [7:0] cr_din;
  logic [7:0] cr_dout;
  logic [2:0] cr_adr;
  logic       cr_we;
  logic       cr_cs;

  always #5 clk = ~clk;

  xint_cond #(.SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst      (rst),
    .XINT_PIN (XINT_PIN),
    .INT_OUT  (INT_OUT),
    .cr_din   (cr_din),
    .cr_dout  (cr_dout),
    .cr_adr   (cr_adr),
    .cr_we    (cr_we),
    .cr_cs    (cr_cs)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got 0x%02h, expected 0x%02h", name, $time, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model. Pins travel through an SS-deep delay queue; the
  // debounce is tracked as "consecutive disagreeing ticks"; the prescaler as
  // clocks since its last restart.
  // ---------------------------------------------------------------------
  logic [7:0] m_sync[$];       // [0] newest sample, [SS-1] is RAW
  logic [7:0] m_filt, m_filt_d, m_int;
  logic [7:0] m_dben, m_dbpre;
  logic [3:0] m_dbth;
  logic [1:0] m_mode[8];
  int         m_streak[8];
  int         m_pre;

  logic [7:0] exp_q[$];
  int         hi_cnt[8];

  function automatic void model_reset();
    m_sync.delete();
    for (int k = 0; k < SS; k++) m_sync.push_back(8'h00);
    m_filt = 0; m_filt_d = 0; m_int = 0;
    m_dben = 0; m_dbpre = 0; m_dbth = 0; m_pre = 0;
    for (int c = 0; c < 8; c++) begin
      m_mode[c]   = 2'b00;
      m_streak[c] = 0;
    end
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  function automatic void model_edge();
    logic [7:0] raw, nf, nint;
    logic       tick, cfgw;
    raw  = m_sync[SS-1];
    tick = (m_pre == int'(m_dbpre));
    cfgw = cr_cs && cr_we && (cr_adr inside {3'd2, 3'd3, 3'd4});
    nf   = m_filt;
    nint = 8'h00;
    for (int c = 0; c < 8; c++) begin
      if (!m_dben[c]) begin
        nf[c] = raw[c];
        m_streak[c] = 0;
      end else if (cfgw || raw[c] == m_filt[c]) begin
        m_streak[c] = 0;
      end else if (tick) begin
        if (m_streak[c] + 1 > int'(m_dbth)) begin
          nf[c] = raw[c];
          m_streak[c] = 0;
        end else begin
          m_streak[c]++;
        end
      end
      case (m_mode[c])
        2'b01: nint[c] = (m_filt_d[c] == 1'b0) && (m_filt[c] == 1'b1);
        2'b10: nint[c] = (m_filt_d[c] == 1'b1) && (m_filt[c] == 1'b0);
        2'b11: nint[c] = m_filt[c];
        default: nint[c] = 1'b0;
      endcase
    end
    m_filt_d = m_filt;
    m_filt   = nf;
    m_int    = nint;
    m_pre    = (cfgw || tick) ? 0 : (m_pre + 1) % 256;
    m_sync.push_front(XINT_PIN);
    void'(m_sync.pop_back());
    if (cr_cs && cr_we) begin
      case (cr_adr)
        3'd0: for (int c = 0; c < 4; c++) m_mode[c]   = cr_din[2*c +: 2];
        3'd1: for (int c = 0; c < 4; c++) m_mode[c+4] = cr_din[2*c +: 2];
        3'd2: m_dben  = cr_din;
        3'd3: m_dbpre = cr_din;
        3'd4: m_dbth  = cr_din[3:0];
        default: ;
      endcase
    end
  endfunction

  function automatic logic [7:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {m_mode[3], m_mode[2], m_mode[1], m_mode[0]};
      3'd1: return {m_mode[7], m_mode[6], m_mode[5], m_mode[4]};
      3'd2: return m_dben;
      3'd3: return m_dbpre;
      3'd4: return {4'h0, m_dbth};
      3'd5: return m_sync[SS-1];
      3'd6: return m_filt;
      default: return 8'h00;
    endcase
  endfunction

  // Monitor: one expected INT_OUT per clock, compared mid-cycle.
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      check("int_out", INT_OUT, exp_q.pop_front());
      for (int c = 0; c < 8; c++) hi_cnt[c] += int'(INT_OUT[c]);
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks: inputs change at posedge+1, the model is stepped before
  // the edge that consumes them.
  // ---------------------------------------------------------------------
  task automatic step();
    model_edge();
    @(posedge clk);
    exp_q.push_back(m_int);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cr_cs = 1'b1; cr_we = 1'b1; cr_adr = a; cr_din = d;
    step();
    cr_we = 1'b0; cr_cs = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input string name);
    cr_adr = a;
    #1;
    check(name, cr_dout, model_read(a));
  endtask

  task automatic clr_hi();
    for (int c = 0; c < 8; c++) hi_cnt[c] = 0;
  endtask

  initial begin
    rst = 1'b1; XINT_PIN = 8'h00; cr_din = 8'h00; cr_adr = 3'd0; cr_we = 1'b0; cr_cs = 1'b0;
    model_reset();
    clr_hi();
    repeat (3) @(posedge clk);
    #1;
    check("reset_int_out", INT_OUT, 8'h00);
    for (int a = 0; a < 8; a++) rd(3'(a), "reset_reg");
    @(posedge clk); #1;
    rst = 1'b0;

    // Rising edge, debounce off: pulse exactly SS+2 edges after the pin is sampled.
    wr(3'd0, 8'h01);
    clr_hi();
    XINT_PIN[0] = 1'b1;
    idle(3);
    check("rise_before", INT_OUT, 8'h00);
    step();
    check("rise_pulse", INT_OUT, 8'h01);
    step();
    check("rise_after", INT_OUT, 8'h00);
    idle(10);
    check_int("rise_pulse_count", hi_cnt[0], 1);

    // Falling edge on ch1, then level mode.
    wr(3'd0, 8'h08);
    XINT_PIN[1] = 1'b1;
    idle(6);
    clr_hi();
    XINT_PIN[1] = 1'b0;
    idle(8);
    check_int("fall_pulse_count", hi_cnt[1], 1);
    wr(3'd0, 8'h0C);
    XINT_PIN[1] = 1'b1;
    idle(8);
    check("level_high", INT_OUT, 8'h02);
    XINT_PIN[1] = 1'b0;
    idle(3);
    check("level_hold", INT_OUT, 8'h02);
    step();
    check("level_drop", INT_OUT, 8'h00);

    // Debounce: glitch rejected, long pulse accepted.
    XINT_PIN = 8'h00;
    idle(6);
    wr(3'd2, 8'h01);
    wr(3'd3, 8'h03);
    wr(3'd4, 8'h02);
    wr(3'd0, 8'h01);
    clr_hi();
    XINT_PIN[0] = 1'b1;
    idle(8);
    XINT_PIN[0] = 1'b0;
    idle(30);
    check_int("glitch_pulses", hi_cnt[0], 0);
    XINT_PIN[0] = 1'b1;
    idle(20);
    check_int("debounced_pulses", hi_cnt[0], 1);
    cr_adr = 3'd5; #1;
    check("db_raw", cr_dout, 8'h01);
    cr_adr = 3'd6; #1;
    check("db_filt", cr_dout, 8'h01);
    wr(3'd2, 8'h00);

    // All channels rising together.
    XINT_PIN = 8'h00;
    idle(6);
    wr(3'd0, 8'h55);
    wr(3'd1, 8'h55);
    clr_hi();
    XINT_PIN = 8'hFF;
    idle(3);
    check("all_before", INT_OUT, 8'h00);
    step();
    check("all_pulse", INT_OUT, 8'hFF);
    step();
    check("all_after", INT_OUT, 8'h00);

    // Randomized pins, register writes and readback.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 7) == 0) XINT_PIN ^= 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        cr_cs = 1'b1; cr_we = 1'b1;
        cr_adr = 3'($urandom_range(0, 7));
        cr_din = (cr_adr == 3'd3 || cr_adr == 3'd4) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      end else begin
        cr_cs = 1'b1; cr_we = 1'b0;
        cr_adr = 3'($urandom_range(0, 7));
        #1;
        check("rand_read", cr_dout, model_read(cr_adr));
      end
      step();
      cr_we = 1'b0; cr_cs = 1'b0;
    end

    // Reset in the middle of a long debounce count.
    wr(3'd2, 8'hFF);
    wr(3'd3, 8'h07);
    wr(3'd4, 8'h0F);
    XINT_PIN = 8'h00;
    idle(4);
    XINT_PIN = 8'hFF;
    idle(10);
    rst = 1'b1;
    #1;
    exp_q.delete();
    model_reset();
    check("midrst_int_out", INT_OUT, 8'h00);
    for (int a = 0; a < 8; a++) begin
      cr_adr = 3'(a); #1;
      check("midrst_reg", cr_dout, 8'h00);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wr(3'd0, 8'h55);
    wr(3'd1, 8'h55);
    clr_hi();
    idle(8);
    for (int c = 0; c < 8; c++) check_int("post_rst_pulse", hi_cnt[c], 1);
    wr(3'd5, 8'h00);
    cr_adr = 3'd5; #1;
    check("raw_write_ignored", cr_dout, 8'hFF);
    wr(3'd7, 8'hAA);
    cr_adr = 3'd7; #1;
    check("rsvd_reads_zero", cr_dout, 8'h00);

    // Let the monitor drain the final expectations.
    repeat (2) @(posedge clk);
    check_int("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
